// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: configuration, serial input and match outputs of the sequence detector
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               x_valid;
    logic               x;
    logic               cnt_clr;
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, x_valid, x, cnt_clr,
        input  z, match_count, cfg_err
    );
    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, x_valid, x, cnt_clr,
        output z, match_count, cfg_err
    );
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: programmable serial pattern detector with overlap mode and saturating match counter
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1101,
    parameter logic [LEN_W-1:0]   RST_LEN     = 4,
    parameter logic               RST_OVERLAP = 1'b0
) (
    input logic clk,
    input logic rst_n,
    seq_detector_param_if.slave bus
);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    logic [MAX_LEN-1:0] pattern, hist_new, mask;
    // only the newest MAX_LEN-1 bits are stored; the incoming bit completes the window
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   len, fill, fill_new;
    logic               overlap, accept, match;
    always_comb begin
        accept   = bus.x_valid && !bus.cfg_load;
        hist_new = {hist, bus.x};
        fill_new = fill == MAX_L ? fill : fill + 1'b1;
        mask     = ~({MAX_LEN{1'b1}} << len);
        match    = accept && !bus.cfg_err && fill_new >= len && ((hist_new ^ pattern) & mask) == '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern         <= RST_PATTERN;
            len             <= RST_LEN;
            overlap         <= RST_OVERLAP;
            hist            <= '0;
            fill            <= '0;
            bus.z           <= 1'b0;
            bus.match_count <= '0;
            bus.cfg_err     <= 1'b0;
        end else begin
            bus.z <= match;
            if (bus.cnt_clr)
                bus.match_count <= '0;
            else if (match && bus.match_count != '1)
                bus.match_count <= bus.match_count + 1'b1;
            if (bus.cfg_load) begin
                pattern     <= bus.cfg_pattern;
                len         <= bus.cfg_len;
                overlap     <= bus.cfg_overlap;
                bus.cfg_err <= bus.cfg_len == '0 || bus.cfg_len > MAX_L;
                hist        <= '0;
                fill        <= '0;
            end else if (bus.x_valid) begin
                hist <= hist_new[MAX_LEN-2:0];
                fill <= (match && !overlap) ? '0 : fill_new;
            end
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: randomized and directed scoreboard bench against a queue-based reference model
module tb_seq_detector_param;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CMAX    = (1 << CNT_W) - 1;

    typedef struct {
        logic             z;
        logic [CNT_W-1:0] cnt;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();
    seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int zp = 0;
    int zmark = 0;

    logic [MAX_LEN-1:0] m_pat;
    int m_len, fresh, m_cnt;
    bit m_ov, m_err;
    bit bq[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic cyc(input bit rn, input bit ld, input logic [MAX_LEN-1:0] pat, input int len,
                       input bit ov, input bit xv, input bit xb, input bit clr);
        exp_t e;
        bit hit;
        @(negedge clk);
        rst_n = rn;
        bus.cfg_load = ld;
        bus.cfg_pattern = pat;
        bus.cfg_len = LEN_W'(len);
        bus.cfg_overlap = ov;
        bus.x_valid = xv;
        bus.x = xb;
        bus.cnt_clr = clr;
        hit = 0;
        if (!rn) begin
            m_pat = 8'h0D; m_len = 4; m_ov = 0; m_err = 0;
            bq.delete(); fresh = 0; m_cnt = 0;
        end else begin
            if (ld) begin
                m_pat = pat; m_len = len; m_ov = ov;
                m_err = (len == 0 || len > MAX_LEN);
                bq.delete(); fresh = 0;
            end else if (xv) begin
                bq.push_back(xb);
                if (bq.size() > MAX_LEN) void'(bq.pop_front());
                fresh++;
                if (!m_err && fresh >= m_len) begin
                    hit = 1;
                    for (int i = 0; i < m_len; i++)
                        if (bq[bq.size() - 1 - i] != m_pat[i]) hit = 0;
                end
                if (hit && !m_ov) fresh = 0;
            end
            if (clr) m_cnt = 0;
            else if (hit && m_cnt < CMAX) m_cnt++;
        end
        e.z = hit;
        e.cnt = CNT_W'(m_cnt);
        e.err = m_err;
        q.push_back(e);
    endtask

    task automatic bit_in(input bit b);
        cyc(1, 0, '0, 0, 0, 1, b, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic stream(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = v;
        for (int i = n - 1; i >= 0; i--) bit_in(t[i]);
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #2;
        check("drain", q.size(), 0);
    endtask

    task automatic expect_pulses(input string name, input int n);
        drain();
        check(name, zp - zmark, n);
        zmark = zp;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("z", bus.z, e.z);
                check("match_count", bus.match_count, e.cnt);
                check("cfg_err", bus.cfg_err, e.err);
                if (bus.z === 1'b1) zp++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cfg_load = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
        bus.x_valid = 0; bus.x = 0; bus.cnt_clr = 0;
        cyc(0, 0, '0, 0, 0, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0, 0, 0);
        expect_pulses("reset_pulses", 0);
        stream(32'b1101101, 7);
        idle(2);
        expect_pulses("default_nonoverlap", 1);
        cyc(1, 1, 8'h0D, 4, 1, 0, 0, 0);
        stream(32'b1101101, 7);
        idle(2);
        expect_pulses("overlap_1101", 2);
        cyc(0, 0, '0, 0, 0, 0, 0, 0);
        bit_in(1); bit_in(1);
        idle(3);
        bit_in(0); bit_in(1);
        idle(2);
        expect_pulses("gapped_stream", 1);
        cyc(1, 1, 8'hFF, 0, 0, 0, 0, 0);
        stream(32'hFFFF, 16);
        stream($urandom, 16);
        expect_pulses("len0_no_match", 0);
        cyc(1, 1, 8'hA5, 8, 0, 0, 0, 0);
        stream(32'b10100101, 8);
        idle(1);
        expect_pulses("len8_a5", 1);
        cyc(1, 1, 8'h01, 1, 1, 0, 0, 1);
        stream(32'b11111, 5);
        expect_pulses("len1_five_ones", 5);
        cyc(1, 0, '0, 0, 0, 1, 1, 1);
        idle(1);
        expect_pulses("clr_with_match", 1);
        cyc(1, 1, 8'h01, 1, 0, 0, 0, 0);
        stream(32'b10110, 5);
        expect_pulses("len1_nonoverlap", 3);
        cyc(0, 0, '0, 0, 0, 0, 0, 0);
        stream(32'b110, 3);
        cyc(0, 0, '0, 0, 0, 0, 0, 0);
        bit_in(1);
        idle(2);
        expect_pulses("reset_mid_seq", 0);
        cyc(1, 1, 8'h06, 3, 1, 1, 1, 0);
        stream(32'b0110110, 7);
        expect_pulses("load_drops_bit", 2);
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 39) == 0, MAX_LEN'($urandom),
                $urandom_range(0, 10), 1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
                $urandom_range(0, 29) == 0);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-sequence detector with a run-time programmable pattern of 1..MAX_LEN bits. Mode selects overlapping or non-overlapping matching. Qualified input via x_valid, registered one-cycle match pulse, and a saturating match counter. Used by the serial front-end to flag sync words and markers; the defaults reproduce the fixed "1101" non-overlapping detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2)
- LEN_W, 4, width of cfg_len; must hold MAX_LEN
- CNT_W, 8, width of match_count
- RST_PATTERN, 8'b0000_1101, pattern loaded at reset (LSB-aligned)
- RST_LEN, 4, pattern length loaded at reset
- RST_OVERLAP, 0, overlap mode loaded at reset

Ports:
- clk, input, 1, clock; all state updates on rising edge
- rst_n, input, 1, synchronous active-low reset
- cfg_load, input, 1, latch cfg_* this cycle and clear detection history
- cfg_pattern, input, MAX_LEN, pattern; bit [len-1] is received first, bit [0] last
- cfg_len, input, LEN_W, pattern length; valid range 1..MAX_LEN
- cfg_overlap, input, 1, 1 = overlapping matches, 0 = non-overlapping
- x_valid, input, 1, x is sampled only when high
- x, input, 1, serial data bit
- cnt_clr, input, 1, synchronous clear of match_count
- z, output, 1, match pulse, one cycle
- match_count, output, CNT_W, number of matches, saturating
- cfg_err, output, 1, latched config is invalid (len 0 or > MAX_LEN)

Behaviour:
- Reset (rst_n=0 at clk edge): pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP. History and fill counter cleared. z=0, match_count=0, cfg_err=0. Reset overrides every other input.
- Internal state: hist[MAX_LEN-1:0] shift register (hist[0] newest) and fill counter 0..MAX_LEN (saturating), giving the number of valid history bits.
- Accepted bit: x_valid=1 and cfg_load=0. On it, hist <= {hist[MAX_LEN-2:0], x} and fill increments.
- Match condition, evaluated on an accepted bit using the new history: len valid, fill_new >= len, and new_hist[len-1:0] == pattern[len-1:0].
- z is registered. It is 1 exactly in the cycle after the edge that accepted the final pattern bit, and 0 otherwise. Latency is 1 cycle from the sampling edge.
- z stays 0 on cycles without an accepted bit. There is no re-pulse while x_valid is low.
- Overlap=1: history is kept after a match, so suffix/prefix overlaps match again.
- Overlap=0: on a match, fill is forced to 0, so the next match needs len fresh bits. The bit that completes the match is not reused.
- cfg_load=1: pattern, len and overlap are latched from cfg_*. History and fill are cleared, z=0 next cycle, and x is ignored that cycle. match_count is unchanged.
- cfg_err is updated on cfg_load: 1 if cfg_len==0 or cfg_len>MAX_LEN. While cfg_err=1, no matches occur and the shift register keeps running.
- match_count increments by 1 on each match and saturates at 2^CNT_W-1 (no wrap).
- cnt_clr=1 sets match_count to 0. Clear has priority over a simultaneous match; z still pulses.
- Simultaneous cfg_load and x_valid: cfg_load wins and the bit is dropped.
- Reset mid-sequence: partial history is discarded and z is 0 the next cycle.
- len=1: every accepted bit equal to pattern[0] pulses z. In overlap=0 mode the result is identical.

Test Plan:
- Default config, x_valid=1, stream 1,1,0,1,1,0,1 -> z high exactly once, in the cycle after bit 4; match_count=1.
- cfg_load pattern=0x0D, len=4, overlap=1; same stream -> z after bits 4 and 7; match_count=2.
- Default config, stream 1,1,0,1 with x_valid low for 3 cycles between bits 2 and 3 -> single z pulse after bit 4 is accepted; z=0 during the gaps.
- cfg_load len=0 -> cfg_err=1, no z for any stream. Then cfg_load len=8, pattern=0xA5, stream 10100101 -> cfg_err=0, z after bit 8.
- CNT_W=2, overlap=1, pattern "1" len=1, stream of five 1s -> five z pulses; match_count saturates at 3. Then cnt_clr coincident with a match -> match_count=0, z=1.
- Stream 1,1,0 then rst_n=0 for one cycle, then 1 -> no z; z=0 and match_count=0 after reset.
